// File: rtl/axil_cfg_master.sv
// axil_cfg_master
//   Single-outstanding AXI4-Lite initiator. It turns a command/response
//   handshake stream into one AXI4-Lite write or read at a time. A per-transaction
//   cycle budget aborts the transfer if the responder never replies.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (accepted only in IDLE)
//   cmd_write                    1 = write, 0 = read
//   cmd_addr/cmd_wdata/cmd_wstrb command payload (addr bits [1:0] forced to 0)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_resp           read data (0 for writes), BRESP/RRESP or 2'b10
//   rsp_timeout                  transaction was aborted by the timeout
//   busy                         high whenever not IDLE
//   aw*/w*/b*/ar*/r*             AXI4-Lite master channels
module axil_cfg_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  tmo_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign tmo_expired = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    tmo_cnt_d     = tmo_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // awvalid/wvalid are !done, so a ready seen while not done is a handshake.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (tmo_expired) begin
          state_d = RSP;
        end else if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        // A B beat in the expiry cycle still counts as a normal completion.
        if (bvalid) begin
          rsp_resp_d    = bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (tmo_expired) begin
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (tmo_expired) begin
          state_d = RSP;
        end else if (arready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          rsp_resp_d    = rresp;
          rsp_rdata_d   = rdata;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (tmo_expired) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort path: every branch above that chose RSP without a completion is a timeout.
    if (state_q != RSP && state_q != IDLE && state_d == RSP && !(
        (state_q == WR_RESP && bvalid) || (state_q == RD_RESP && rvalid))) begin
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  // Every handshake output is a pure function of registered state, so the
  // asynchronous reset clears them immediately. cmd_ready is also gated by
  // rst_n so nothing is offered while reset is held.
  assign cmd_ready   = (state_q == IDLE) && rst_n;
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign bready  = (state_q == WR_RESP);
  assign arvalid = (state_q == RD_REQ);
  assign rready  = (state_q == RD_RESP);

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign awprot = 3'b000;
  assign arprot = 3'b000;

endmodule

// File: tb/tb_axil_cfg_master.sv
module tb_axil_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, busy;
  logic        awvalid, awready;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_assert = 0;
  int n_fail   = 0;
  int b_hs     = 0;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always @(posedge clk) begin
    if (bvalid && bready) b_hs <= b_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}), 32'd0);
    chk("rst_addr", 32'({awaddr, araddr}), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb_prot", 32'({wstrb, awprot, arprot}), 32'd0);
    chk("rst_rsp", 32'({rsp_resp, rsp_timeout}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Unsolicited B/R beats in IDLE are not accepted
    bvalid = 1'b1; rvalid = 1'b1;
    tick();
    chk("unsol_bready", 32'(bready), 32'd0);
    chk("unsol_rready", 32'(rready), 32'd0);
    chk("unsol_busy", 32'(busy), 32'd0);
    bvalid = 1'b0; rvalid = 1'b0;

    // Write 0x08 <- 0x1F4, zero-wait slave
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 4'h8, 32'h0000_01F4, 4'hF);
    tick();  // cycle 0 accept
    cmd_valid = 1'b0;
    chk("w1_awvalid", 32'(awvalid), 32'd1);
    chk("w1_wvalid", 32'(wvalid), 32'd1);
    chk("w1_awaddr", 32'(awaddr), 32'h8);
    chk("w1_wdata", wdata, 32'h0000_01F4);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("w1_busy", 32'(busy), 32'd1);
    tick();  // cycle 1 AW/W handshake
    chk("w1_valids_drop", 32'({awvalid, wvalid}), 32'd0);
    chk("w1_bready", 32'(bready), 32'd1);
    chk("w1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();  // cycle 2 B handshake
    chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("w1_no_cmd_ready", 32'(cmd_ready), 32'd0);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_back_idle", 32'({cmd_ready, rsp_valid, busy}), 32'b100);
    chk("w1_b_count", 32'(b_hs), 32'd1);

    // Read 0x0C, arready after 2 wait cycles, then hold rsp_ready low 5 cycles
    issue(1'b0, 4'hC, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("r1_arvalid_c1", 32'(arvalid), 32'd1);
    chk("r1_araddr", 32'(araddr), 32'hC);
    tick();
    chk("r1_arvalid_c2", 32'(arvalid), 32'd1);
    tick();
    chk("r1_arvalid_c3", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r1_arvalid_drop", 32'(arvalid), 32'd0);
    chk("r1_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'h0000_01F4; rresp = 2'b00;
    tick();
    rdata = 32'hFFFF_FFFF; rresp = 2'b11;
    chk("r1_rready_drop", 32'(rready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0000_01F4);
      chk("hold_rsp_resp", 32'({rsp_resp, rsp_timeout}), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rvalid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r1_back_idle", 32'(cmd_ready), 32'd1);

    // Write with W handshake 3 cycles after AW
    awready = 1'b1; wready = 1'b0;
    issue(1'b1, 4'h4, 32'hA5A5_A5A5, 4'h3);
    tick();
    cmd_valid = 1'b0;
    chk("w2_both_valid", 32'({awvalid, wvalid}), 32'b11);
    tick();  // AW handshake
    awready = 1'b0;
    chk("w2_aw_drop", 32'({awvalid, wvalid}), 32'b01);
    tick();
    chk("w2_w_held1", 32'({awvalid, wvalid}), 32'b01);
    tick();
    chk("w2_w_held2", 32'({awvalid, wvalid, bready}), 32'b010);
    wready = 1'b1;
    tick();  // W handshake
    wready = 1'b0;
    chk("w2_w_drop", 32'({awvalid, wvalid, bready}), 32'b001);
    bvalid = 1'b1; bresp = 2'b01;
    tick();
    bvalid = 1'b0;
    chk("w2_rsp", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'b1010);
    chk("w2_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w2_b_count", 32'(b_hs), 32'd2);

    // Write with AW handshake 3 cycles after W
    wready = 1'b1; awready = 1'b0;
    issue(1'b1, 4'h0, 32'h0000_0055, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();  // W handshake
    wready = 1'b0;
    chk("w3_w_drop", 32'({awvalid, wvalid}), 32'b10);
    tick();
    tick();
    chk("w3_aw_held", 32'({awvalid, wvalid, bready}), 32'b100);
    awready = 1'b1;
    tick();  // AW handshake
    awready = 1'b0;
    chk("w3_aw_drop", 32'({awvalid, wvalid, bready}), 32'b001);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("w3_rsp", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'b1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w3_b_count", 32'(b_hs), 32'd3);

    // Read timeout: R never arrives, budget of 8 cycles
    arready = 1'b1; rvalid = 1'b0;
    issue(1'b0, 4'h0, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();  // AR handshake
    arready = 1'b0;
    chk("to_rready_c1", 32'(rready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to_waiting", 32'({rready, rsp_valid}), 32'b10);
    end
    tick();  // counter expiry
    chk("to_rready_drop", 32'(rready), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_resp", 32'(rsp_resp), 32'h2);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_cmd_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_back_idle", 32'(cmd_ready), 32'd1);

    // Next command after timeout: unaligned read 0x7 -> araddr 0x4
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0123; rresp = 2'b00;
    issue(1'b0, 4'h7, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("ua_araddr", 32'(araddr), 32'h4);
    chk("ua_arvalid", 32'(arvalid), 32'd1);
    tick();
    chk("ua_rready", 32'(rready), 32'd1);
    tick();
    chk("ua_rsp", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'b1000);
    chk("ua_rdata", rsp_rdata, 32'hCAFE_0123);
    arready = 1'b0; rvalid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while in WR_REQ
    issue(1'b1, 4'h4, 32'h1111_2222, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("rw_awvalid_pre", 32'(awvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_valids_async", 32'({awvalid, wvalid}), 32'd0);
    chk("rw_busy", 32'({busy, rsp_valid}), 32'd0);
    chk("rw_awaddr", 32'(awaddr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 4'hC, 32'h1234_5678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("pr_awaddr", 32'(awaddr), 32'hC);
    chk("pr_wdata", wdata, 32'h1234_5678);
    tick();
    tick();
    chk("pr_rsp", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'b1000);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("pr_idle", 32'(cmd_ready), 32'd1);
    chk("pr_b_count", 32'(b_hs), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cfg_master.md
Name: axil_cfg_master

Overview:
Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into AXI4-Lite write and read transactions. It drives the peripheral's slave port from a bring-up sequencer, a test harness, or an on-chip controller. All five AXI channels are handled, including AW/W completing in either order. A programmable timeout terminates a transaction if the responder never replies.

Parameters:
ADDR_WIDTH, 4, width of cmd_addr/awaddr/araddr; data width is fixed at 32.
TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; must be >= 4.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes (ignored on reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  high in any state other than IDLE
awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3]  AXI write-address channel
wvalid/wready/wdata[32]/wstrb[4]  AXI write-data channel
bvalid/bready/bresp[2]  AXI write-response channel
arvalid/arready/araddr[ADDR_WIDTH]/arprot[3]  AXI read-address channel
rvalid/rready/rdata[32]/rresp[2]  AXI read-data channel

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all valid/ready outputs 0, addresses/data 0, prot 3'b000, rsp_* 0, busy 0, state IDLE, timeout counter 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready = 1 (combinational, state==IDLE only). On cmd_valid, latch the command.
  - Write: go to WR_REQ; awvalid and wvalid both high the next cycle.
  - Read: go to RD_REQ; arvalid high the next cycle.
- WR_REQ:
  - awvalid drops in the cycle after its own handshake; wvalid drops in the cycle after its own handshake. The two channels are tracked by independent done flags.
  - A valid never drops before its handshake, except on timeout.
  - When both flags are set (same cycle or different cycles), go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture bresp and go to RSP.
- RD_REQ: hold arvalid until arready, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata and rresp and go to RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata, rsp_resp and rsp_timeout are stable until rsp_ready, then return to IDLE.
  - Writes report rsp_rdata = 0.
  - rsp_valid and cmd_ready are never high together.
- Minimum latency with an always-ready, zero-wait slave:
  - cmd accepted at cycle 0.
  - AW/W (or AR) handshake at cycle 1.
  - B/R handshake at cycle 2 earliest.
  - rsp_valid at cycle 3.
- Timeout:
  - The counter clears on command accept and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - On reaching TIMEOUT_CYCLES-1 without completion, all AXI valid/ready outputs drop next cycle and the block goes to RSP with rsp_resp = 2'b10 and rsp_timeout = 1.
  - This intentional protocol abort is for debug recovery; the responder must be reset afterwards.
  - A completion in the same cycle as expiry counts as completion, not timeout.
- Unsolicited bvalid/rvalid outside the *_RESP states is ignored: bready/rready stay 0.
- Reset mid-transaction: all outputs return to reset values asynchronously and any pending response is discarded.

Test Plan:
- Write 0x08 <- 0x000001F4, wstrb 4'hF, slave always ready, bresp 2'b00 -> awaddr = 0x8, wdata = 0x1F4, rsp_valid at cycle 3 with rsp_resp 00, rsp_rdata 0, rsp_timeout 0.
- Read 0x0C; slave arready after 2 wait cycles, rdata 0x000001F4, rresp 00 -> arvalid held 3 cycles, rsp_rdata 0x1F4.
- Write where wready arrives 3 cycles after awready, then the reverse order -> each valid drops only after its own handshake, exactly one B handshake, one response each time.
- Read with rvalid never asserted, TIMEOUT_CYCLES = 8 -> rready drops, rsp_resp 2'b10 and rsp_timeout 1, next command accepted after rsp_ready.
- Hold rsp_ready low for 5 cycles after a read -> rsp fields stable, cmd_ready 0 throughout. Unaligned cmd_addr 0x7 -> araddr 0x4.
- Assert rst_n low while in WR_REQ -> awvalid/wvalid 0 immediately, busy 0. A write after release completes normally.
